axis_mult_pipe: RTL

//  Pipelined AXI4-Stream scaler: each beat r = sat((a * coef) >>> SHIFT) with full backpressure.

---
 rtl/axis_mult_pkg.sv | 42 ++++
 rtl/axis_pipe_stage.sv | 34 +++
 rtl/axis_mult_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/axis_mult_pkg.sv
// Shared constants and saturation helpers for the AXI4-Stream scaling pipeline.
package axis_mult_pkg;

  localparam int unsigned STAGES_MIN = 2;
  localparam int unsigned STAGES_MAX = 6;
  // Working width of the post-shift value handed to the clamp decision.
  localparam int unsigned MAX_W      = 64;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_sel_e;

  function automatic int unsigned prod_width(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w;
  endfunction

  // Decides whether x fits an out_w-bit result; x is sign- or zero-extended to MAX_W.
  function automatic sat_sel_e sat_select(input logic [MAX_W-1:0] x, input int unsigned out_w,
                                          input bit is_signed);
    logic signed [MAX_W-1:0] s_hi;
    logic signed [MAX_W-1:0] s_lo;
    logic [MAX_W-1:0]        u_hi;
    sat_sel_e                sel;
    sel  = SAT_NONE;
    s_hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    s_lo = ~s_hi;
    u_hi = (64'd1 << out_w) - 64'd1;
    if (is_signed) begin
      if ($signed(x) > s_hi) begin
        sel = SAT_HI;
      end else if ($signed(x) < s_lo) begin
        sel = SAT_LO;
      end
    end else if (x > u_hi) begin
      sel = SAT_HI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_pipe_stage.sv
// One valid/ready register slice: loads whenever its advance is high, else holds.
module axis_pipe_stage
  import axis_mult_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_adv,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/axis_mult_pipe.sv
// Pipelined AXI4-Stream scaler: r = sat((a * coef) >>> SHIFT), full backpressure,
// tlast carried alongside data, sticky saturation flag and completed-frame counter.
module axis_mult_pipe
  import axis_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned STAGES = 3,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [COEF_W-1:0] coef,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              sat_flag,
  input  logic              sat_clr,
  output logic [31:0]       frame_cnt
);

  localparam int unsigned PROD_W = prod_width(DATA_W, COEF_W);

  logic [STAGES:1]           w_v;
  logic [STAGES+1:1]         w_adv;
  logic [PROD_W-1:0]         w_prod;
  logic [PROD_W-1:0]         w_s1_prod;
  logic                      w_s1_last;
  logic [MAX_W-1:0]          w_shifted;
  sat_sel_e                  w_sel;
  logic [DATA_W-1:0]         w_clamped;
  logic                      w_s2_sat;
  logic [STAGES:2][DATA_W:0] w_pl;
  logic                      r_sat_flag;
  logic [31:0]               r_frame_cnt;

  // A stage may load when it is empty or the stage after it is loading too.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES+1] = m_axis_tready;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      w_adv[k] = !w_v[k] | w_adv[k+1];
    end
  end

  always_comb begin
    if (SIGNED) begin
      w_prod = PROD_W'($signed(s_axis_tdata)) * PROD_W'($signed(coef));
    end else begin
      w_prod = PROD_W'(s_axis_tdata) * PROD_W'(coef);
    end
  end

  axis_pipe_stage #(.PW(PROD_W + 1)) u_stage_mul (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_adv   (w_adv[1]),
    .i_valid (s_axis_tvalid),
    .i_data  ({s_axis_tlast, w_prod}),
    .o_valid (w_v[1]),
    .o_data  ({w_s1_last, w_s1_prod})
  );

  always_comb begin
    if (SIGNED) begin
      w_shifted = MAX_W'($signed(w_s1_prod)) >>> SHIFT;
    end else begin
      w_shifted = MAX_W'(w_s1_prod) >> SHIFT;
    end
    w_sel = sat_select(w_shifted, DATA_W, SIGNED);
    case (w_sel)
      SAT_HI: begin
        if (SIGNED) begin
          w_clamped = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
          w_clamped = '1;
        end
      end
      SAT_LO:  w_clamped = {1'b1, {(DATA_W-1){1'b0}}};
      default: w_clamped = w_shifted[DATA_W-1:0];
    endcase
  end

  axis_pipe_stage #(.PW(DATA_W + 2)) u_stage_sat (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_adv   (w_adv[2]),
    .i_valid (w_v[1]),
    .i_data  ({w_sel != SAT_NONE, w_s1_last, w_clamped}),
    .o_valid (w_v[2]),
    .o_data  ({w_s2_sat, w_pl[2]})
  );

  for (genvar k = 3; k <= STAGES; k++) begin : g_delay
    axis_pipe_stage #(.PW(DATA_W + 1)) u_stage (
      .i_clk   (aclk),
      .i_rst   (areset),
      .i_adv   (w_adv[k]),
      .i_valid (w_v[k-1]),
      .i_data  (w_pl[k-1]),
      .o_valid (w_v[k]),
      .o_data  (w_pl[k])
    );
  end

  // The saturation flag records the beat as it leaves the sat stage; clear has priority.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sat_flag  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (sat_clr) begin
        r_sat_flag <= 1'b0;
      end else if (w_v[2] && w_adv[3] && w_s2_sat) begin
        r_sat_flag <= 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  assign s_axis_tready = w_adv[1] & !areset;
  assign m_axis_tvalid = w_v[STAGES];
  assign {m_axis_tlast, m_axis_tdata} = w_pl[STAGES];
  assign sat_flag      = r_sat_flag;
  assign frame_cnt     = r_frame_cnt;

endmodule
